// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared route FSM encoding and default sizes for demux_1_2
package demux_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ROUTE0 = 2'd1;
  localparam state_t ROUTE1 = 2'd2;

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry valid/ready register slice with load, drain and load+drain
module demux_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  output logic             free,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             last_q, last_d;

  // A draining slot can take a new beat in the same cycle, giving full throughput.
  assign free = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      last_d  = load_last;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;

endmodule

// File: rtl/demux_1_2.sv
// rtl/demux_1_2.sv - registered 1-to-2 packet demux; route held per packet
// Optional per-output packet counters are built only with DEMUX_STATS_EN.
module demux_1_2
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_last,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_last,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_last,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  state_t state_q, state_d;
  logic   route;
  logic   accept;
  logic   free0, free1;

  always_comb begin
    case (state_q)
      ROUTE0:  route = 1'b0;
      ROUTE1:  route = 1'b1;
      default: route = in_sel;
    endcase
  end

  // Held low in reset so nothing is accepted before the slots are cleared.
  assign in_ready = rst_n && (route ? free1 : free0);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        IDLE:    if (!in_last) state_d = in_sel ? ROUTE1 : ROUTE0;
        ROUTE0,
        ROUTE1:  if (in_last) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  demux_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept && !route),
    .load_data (in_data),
    .load_last (in_last),
    .free      (free0),
    .out_valid (out0_valid),
    .out_ready (out0_ready),
    .out_data  (out0_data),
    .out_last  (out0_last)
  );

  demux_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept && route),
    .load_data (in_data),
    .load_last (in_last),
    .free      (free1),
    .out_valid (out1_valid),
    .out_ready (out1_ready),
    .out_data  (out1_data),
    .out_last  (out1_last)
  );

`ifdef DEMUX_STATS_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

  // Clear wins over a same-cycle increment; counts saturate at all-ones.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (stats_clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else begin
      if (out0_valid && out0_ready && out0_last && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_ONE;
      if (out1_valid && out1_ready && out1_last && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign pkt_cnt0 = '0;
  assign pkt_cnt1 = '0;
`endif

endmodule

// File: tb/tb_demux_1_2.sv
// tb/tb_demux_1_2.sv - directed self-checking bench for demux_1_2
module tb_demux_1_2;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
`ifdef DEMUX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_sel, in_last;
  logic [WIDTH-1:0] in_data;
  logic             out0_valid, out0_ready, out0_last;
  logic             out1_valid, out1_ready, out1_last;
  logic [WIDTH-1:0] out0_data, out1_data;
  logic             stats_clr;
  logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  demux_1_2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sel     (in_sel),
    .in_last    (in_last),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out0_last  (out0_last),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out1_last  (out1_last),
    .stats_clr  (stats_clr),
    .pkt_cnt0   (pkt_cnt0),
    .pkt_cnt1   (pkt_cnt1)
  );

  task automatic check_eq(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fails++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic sel, input logic last, input logic [WIDTH-1:0] data);
    in_valid = 1'b1;
    in_sel   = sel;
    in_last  = last;
    in_data  = data;
  endtask

  function automatic logic [63:0] cnt_exp(input int v);
    return STATS ? 64'(v) : 64'd0;
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_last = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0; stats_clr = 1'b0;
    #3;
    check_eq("rst_out0_valid", out0_valid, 0);
    check_eq("rst_out1_valid", out1_valid, 0);
    check_eq("rst_out0_data", out0_data, 0);
    check_eq("rst_out1_last", out1_last, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_cnt0", pkt_cnt0, 0);
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;

    // single-beat packet to out1
    beat(1'b1, 1'b1, 32'hA5A5_A5A5);
    #1 check_eq("single_in_ready", in_ready, 1);
    tick();
    check_eq("single_out1_valid", out1_valid, 1);
    check_eq("single_out1_data", out1_data, 32'hA5A5_A5A5);
    check_eq("single_out1_last", out1_last, 1);
    check_eq("single_out0_valid", out0_valid, 0);
    in_valid = 1'b0; out1_ready = 1'b1;
    tick();
    check_eq("single_drained", out1_valid, 0);
    check_eq("single_cnt1", pkt_cnt1, cnt_exp(1));

    // 3-beat packet, in_sel toggled after head must be ignored
    out0_ready = 1'b1;
    beat(1'b0, 1'b0, 32'h11);
    tick();
    check_eq("p3_b1_data", out0_data, 32'h11);
    check_eq("p3_b1_last", out0_last, 0);
    beat(1'b1, 1'b0, 32'h22);
    tick();
    check_eq("p3_b2_data", out0_data, 32'h22);
    check_eq("p3_b2_out1_valid", out1_valid, 0);
    beat(1'b1, 1'b1, 32'h33);
    tick();
    check_eq("p3_b3_data", out0_data, 32'h33);
    check_eq("p3_b3_last", out0_last, 1);
    beat(1'b1, 1'b1, 32'h44);
    tick();
    check_eq("p3_idle_routes_out1", out1_valid, 1);
    check_eq("p3_idle_out1_data", out1_data, 32'h44);
    in_valid = 1'b0;
    tick();
    check_eq("p3_cnt0", pkt_cnt0, cnt_exp(1));
    check_eq("p3_cnt1", pkt_cnt1, cnt_exp(2));

    // out0 stalled: new head to 0 must wait
    out0_ready = 1'b0;
    beat(1'b0, 1'b1, 32'h55);
    tick();
    check_eq("stall_out0_data", out0_data, 32'h55);
    beat(1'b0, 1'b1, 32'h66);
    #1 check_eq("stall_in_ready", in_ready, 0);
    tick();
    check_eq("stall_hold_data", out0_data, 32'h55);
    check_eq("stall_hold_valid", out0_valid, 1);
    check_eq("stall_in_ready2", in_ready, 0);
    out0_ready = 1'b1;
    #1 check_eq("stall_release_ready", in_ready, 1);
    tick();
    check_eq("stall_load_drain_data", out0_data, 32'h66);
    check_eq("stall_load_drain_valid", out0_valid, 1);
    check_eq("stall_cnt0", pkt_cnt0, cnt_exp(2));
    in_valid = 1'b0; out0_ready = 1'b0;

    // out0 stalled full, packet to out1 streams at full rate
    for (int i = 0; i < 3; i++) begin
      beat((i == 0) ? 1'b1 : 1'b0, (i == 2), 32'h77 + 32'(i));
      #1 check_eq("hol_in_ready", in_ready, 1);
      tick();
      check_eq("hol_out1_data", out1_data, 32'h77 + 32'(i));
      check_eq("hol_out0_data", out0_data, 32'h66);
    end
    in_valid = 1'b0;
    tick();
    check_eq("hol_out0_valid", out0_valid, 1);
    check_eq("hol_out1_drained", out1_valid, 0);
    check_eq("hol_cnt1", pkt_cnt1, cnt_exp(3));

    // reset during beat 2 of a 4-beat packet
    beat(1'b1, 1'b0, 32'hA1);
    tick();
    check_eq("rstmid_b1_valid", out1_valid, 1);
    beat(1'b1, 1'b0, 32'hA2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstmid_out0_valid", out0_valid, 0);
    check_eq("rstmid_out1_valid", out1_valid, 0);
    check_eq("rstmid_in_ready", in_ready, 0);
    #1 rst_n = 1'b1;
    out0_ready = 1'b0;
    beat(1'b0, 1'b1, 32'hB2);
    tick();
    check_eq("rstmid_new_head_out0", out0_valid, 1);
    check_eq("rstmid_new_head_data", out0_data, 32'hB2);
    check_eq("rstmid_out1_quiet", out1_valid, 0);
    out0_ready = 1'b1;

    // back-to-back single-beat packets alternating outputs
    beat(1'b1, 1'b1, 32'hC1);
    tick();
    check_eq("alt_out1_data", out1_data, 32'hC1);
    beat(1'b0, 1'b1, 32'hC2);
    tick();
    check_eq("alt_out0_data", out0_data, 32'hC2);
    check_eq("alt_out1_drained", out1_valid, 0);

    // saturation: 17 more packets to out0 on top of those already counted
    for (int i = 0; i < 17; i++) begin
      beat(1'b0, 1'b1, 32'(i));
      tick();
      check_eq("sat_out0_data", out0_data, 32'(i));
    end
    in_valid = 1'b0;
    tick();
    check_eq("sat_cnt0", pkt_cnt0, cnt_exp(15));

    // clear wins over a same-cycle increment
    beat(1'b0, 1'b1, 32'hD0);
    out0_ready = 1'b0;
    tick();
    in_valid = 1'b0; out0_ready = 1'b1; stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check_eq("clr_cnt0", pkt_cnt0, 0);
    check_eq("clr_cnt1", pkt_cnt1, 0);
    check_eq("clr_out0_drained", out0_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/demux_1_2.md
# demux_1_2

Registered 1-to-2 packet demultiplexer for the multicycle datapath: the distribution counterpart of the 2:1 selection mux, steering one valid/ready stream to one of two consumers. The route is sampled on the first beat of each packet and held until the beat flagged last. Each output has a one-entry register slice, so the consumer sees registered data one cycle after acceptance.

## Interface
- WIDTH, 32, data width of in_data / outN_data
- CNT_W, 16, width of the per-output packet counters (used only with DEMUX_STATS_EN)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  source beat valid
- in_ready  output  1  block accepts beat this cycle
- in_data  input  WIDTH  beat payload
- in_sel  input  1  destination; sampled only on the first beat of a packet
- in_last  input  1  final beat of packet
- out0_valid / out1_valid  output  1  output slot holds a beat
- out0_ready / out1_ready  input  1  consumer accepts
- out0_data / out1_data  output  WIDTH  registered payload
- out0_last / out1_last  output  1  registered last flag
- stats_clr  input  1  synchronous clear of both counters
- pkt_cnt0 / pkt_cnt1  output  CNT_W  packets delivered per output

## Operation
- FSM states: IDLE, ROUTE0, ROUTE1.
  - IDLE: route is in_sel. On an accepted beat with in_last=0, go to ROUTE{in_sel}. With in_last=1, stay in IDLE.
  - ROUTEn: route is n and in_sel is ignored. On an accepted beat with in_last=1, go to IDLE.
- Transitions occur only on an accepted beat (in_valid & in_ready).
- Slot n is free when outn_valid=0 or outn_ready=1.
- in_ready is 1 when the slot of the current route is free. It is combinational from the route and that slot's ready.
- Accepted beat: loads data and last into the slot of the current route, and sets that slot's valid.
- Slot drain: outn_valid & outn_ready with no new load clears outn_valid.
- Load and drain of the same slot in the same cycle: valid stays 1 and the new data replaces the old. This gives full throughput.
- The two slots are independent. A stalled out1 does not block draining of out0, but it does block input while the route is 1 (head-of-line).
- outn_data and outn_last hold their value while outn_valid=1 and outn_ready=0.

## Timing
- Reset values: state IDLE, out0_valid=out1_valid=0, outN_data=0, outN_last=0, pkt_cnt0=pkt_cnt1=0.
- in_ready during reset: 0.
- Latency: a beat accepted at edge k is visible on outN at edge k (registered), one cycle after presentation. Sustained throughput is 1 beat/cycle per route.
- Reset asserted mid-packet: in-flight beats are discarded, both valids drop immediately, state goes to IDLE. The next accepted beat is treated as a packet head.
- A single-beat packet (in_last on the head beat) never leaves IDLE. Back-to-back single-beat packets may alternate outputs every cycle.

## Configuration
- DEMUX_STATS_EN defined:
  - pkt_cntN increments on each outn_valid & outn_ready & outn_last, and saturates at all-ones.
  - stats_clr zeroes both counters and takes priority over a same-cycle increment.
- DEMUX_STATS_EN undefined: the counter ports still exist and are tied to 0, stats_clr is ignored, and no counter flops are built.

## Structure
- Shared package demux_pkg holds the FSM state typedef (IDLE, ROUTE0, ROUTE1) and the default WIDTH/CNT_W constants.
- One sub-module, demux_slot: a one-entry valid/ready register slice with load, drain and simultaneous load+drain. It is instantiated twice.
- The FSM, in_ready logic and counters stay in the top module.

## Test plan
- Reset then single beat data=0xA5A5A5A5, sel=1, last=1 -> out1_valid=1 with that data and out1_last=1 after one edge; out0_valid stays 0; with stats enabled, pkt_cnt1=1 after the drain.
- 3-beat packet with sel=0 on the head, and in_sel toggled on beats 2-3 -> all three beats appear on out0; state returns to IDLE after the last.
- out0_ready=0 with one beat held in slot 0, then a new head with sel=0 -> in_ready=0 until out0_ready=1; out0_data stays unchanged while stalled.
- out0 stalled full, then a packet with sel=1 -> accepted at full rate on out1; out0 is unaffected.
- Reset pulse during beat 2 of a 4-beat packet -> both valids 0 immediately; the next beat is routed by its own in_sel.
- DEMUX_STATS_EN defined with CNT_W=4 and 17 packets to out0 -> pkt_cnt0 saturates at 15; stats_clr -> 0 on the next edge.
